apb3_reg_slave: RTL and testbench
=================================

# apb3_reg_slave

APB3 completer that terminates transfers issued by the team's `apb3_master`. It exposes a bank of `NUM_REGS` read/write control registers and one read-only status word. Optional wait states are inserted before `PREADY`. Unmapped, misaligned and illegal accesses are reported on `PSLVERR`. It sits on the peripheral side of the APB segment and drives control registers into downstream logic.

## Interface
- `ADDR_WIDTH`, 32: width of `PADDR`.
- `DATA_WIDTH`, 32: register and bus data width.
- `NUM_REGS`, 8: number of RW registers (1..64).
- `WAIT_CYCLES`, 2: wait states per access; used only with `APB3_SLV_WAIT_EN`; range 0..15.
- `PCLK` in 1: clock; all logic rising-edge.
- `PRESET` in 1: **one clock; reset is synchronous and active-high.**
- `PSEL` in 1: slave select.
- `PENABLE` in 1: access phase.
- `PADDR` in `ADDR_WIDTH`: byte address.
- `PWRITE` in 1: 1 = write, 0 = read.
- `PWDATA` in `DATA_WIDTH`: write data.
- `PRDATA` out `DATA_WIDTH`: read data; valid only while `PREADY`=1 on a read, else 0.
- `PREADY` out 1: transfer completes this cycle.
- `PSLVERR` out 1: error response; valid only with `PREADY`=1, else 0.
- `reg_out` out `NUM_REGS*DATA_WIDTH`: flattened RW registers; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `wr_pulse` out `NUM_REGS`: one-cycle strobe, bit i set the cycle after register i is written.
- `status_in` in `DATA_WIDTH`: live status word, read-only at index `NUM_REGS`.

## Operation
- Decode:
  - idx = `PADDR[ADDR_WIDTH-1:2]`.
  - err = (`PADDR[1:0]` != 0) OR (idx > `NUM_REGS`) OR (idx == `NUM_REGS` AND `PWRITE`).
- FSM `IDLE`, `SETUP`, `ACCESS`, tracking the bus phase:
  - `IDLE` -> `SETUP` on `PSEL` & !`PENABLE`.
  - `SETUP` -> `ACCESS` unconditionally.
  - `ACCESS` -> `IDLE` on `PREADY` with `PSEL` low next, or -> `SETUP` for a back-to-back transfer.
  - `ACCESS` holds while `PREADY`=0.
- Protocol violation (`PENABLE`=1 while in `IDLE`): answer `PREADY`=1, `PSLVERR`=1 in that cycle; no register change.
- Write commits at the rising edge where `PSEL` & `PENABLE` & `PREADY` & `PWRITE` & !err. Register idx <= `PWDATA`, and `wr_pulse`[idx] = 1 for the following cycle only.
- Read: `PRDATA` = register idx, or `status_in` for idx == `NUM_REGS`. `PRDATA` = 0 on error.
- Errored transfers never modify state other than the FSM.
- `PSEL` dropping mid-`ACCESS`: abandon the transfer, return to `IDLE`, no write, counter cleared.
- Reset, including mid-transfer: all registers 0, FSM `IDLE`, wait counter 0, `wr_pulse` 0, pending transfer dropped without a write. Outputs `PRDATA`, `PREADY` and `PSLVERR` are 0 while `PRESET`=1.

## Timing
- `PREADY`, `PRDATA` and `PSLVERR` are combinational from registered state, the wait counter and bus inputs. No register sits in the response path.
- Zero-wait: `PREADY`=1 in the first `ACCESS` cycle. A transfer then takes 2 cycles (setup + access).
- With waits: the counter loads `WAIT_CYCLES` in `SETUP` and decrements each `ACCESS` cycle while nonzero. `PREADY` = `ACCESS` & counter==0. A transfer takes 2 + `WAIT_CYCLES` cycles.
- Register update is visible on `reg_out` in the cycle after the completing edge, coincident with `wr_pulse`.
- Back-to-back transfers with no `IDLE` cycle are supported with no lost cycle.

## Configuration
- `APB3_SLV_WAIT_EN` defined: wait counter present and `WAIT_CYCLES` honoured (including 0).
- Not defined: counter logic omitted, `WAIT_CYCLES` ignored, every access is zero-wait.

## Structure
- Shared package `apb3_pkg` holds:
  - the FSM state encoding `IDLE`=2'b00, `SETUP`=2'b01, `ACCESS`=2'b10, common with the master;
  - the `APB3_ADDR_LSB`=2 constant.
- One natural sub-module, `apb3_slv_decode`: combinational address decode producing idx, a one-hot select and err.

## Test plan
- Reset then read idx 0..7 -> `PRDATA`=0, `PSLVERR`=0 for all; `reg_out`=0.
- Write 0xDEADBEEF to 0x0C, read 0x0C, with macro and `WAIT_CYCLES`=2:
  - `PREADY` high exactly in the 3rd `ACCESS` cycle;
  - `wr_pulse`=8'b0000_1000 for one cycle;
  - readback 0xDEADBEEF.
- `status_in`=0x1234 and read 0x20 -> 0x1234. Write 0x20 -> `PSLVERR`=1 and no register changes.
- Access 0x24 and 0x05 -> `PSLVERR`=1, `PRDATA`=0, no `wr_pulse`.
- Back-to-back write 0x00 = 0xA5 then read 0x00, no `IDLE` gap, macro off -> 2 cycles each, read returns 0xA5.
- Assert `PRESET` during the wait phase of a write to 0x04 with value 0x55 -> register 0x04 stays 0, `PREADY` 0, FSM `IDLE`.

Source files
------------

// File: rtl/apb3_pkg.sv
// rtl/apb3_pkg.sv - APB3 shared FSM state encoding and address constants
package apb3_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb3_state_e;

    localparam int APB3_ADDR_LSB = 2;

endpackage

// File: rtl/apb3_slv_decode.sv
// rtl/apb3_slv_decode.sv - APB3 completer address decode: word index, one-hot select, error
module apb3_slv_decode
    import apb3_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic [ADDR_WIDTH-1:0]               paddr,
    input  logic                                pwrite,
    output logic [ADDR_WIDTH-APB3_ADDR_LSB-1:0] idx,
    output logic [NUM_REGS-1:0]                 sel,
    output logic                                err
);

    localparam int IDX_W = ADDR_WIDTH - APB3_ADDR_LSB;

    always_comb begin
        idx = paddr[ADDR_WIDTH-1:APB3_ADDR_LSB];
        // The status word one past the RW bank is readable but never writable
        err = (paddr[APB3_ADDR_LSB-1:0] != '0)
            || (idx > IDX_W'(NUM_REGS))
            || ((idx == IDX_W'(NUM_REGS)) && pwrite);
        for (int i = 0; i < NUM_REGS; i++) begin
            sel[i] = !err && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/apb3_reg_slave.sv
// rtl/apb3_reg_slave.sv - APB3 register completer; APB3_SLV_WAIT_EN enables WAIT_CYCLES wait states
module apb3_reg_slave
    import apb3_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic                           PWRITE,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse,
    input  logic [DATA_WIDTH-1:0]          status_in
);

    localparam int IDX_W = ADDR_WIDTH - APB3_ADDR_LSB;

    if (NUM_REGS < 1 || NUM_REGS > 64 || WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_param
        $error("apb3_reg_slave: NUM_REGS must be 1..64 and WAIT_CYCLES 0..15");
    end

    apb3_state_e                   state_q, state_d, phase;
    logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]           wr_pulse_q, wr_pulse_d;
    logic [IDX_W-1:0]              idx;
    logic [NUM_REGS-1:0]           sel;
    logic                          addr_err;
    logic                          violation;
    logic                          wait_done;
    logic                          ready;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         rd_data;

    apb3_slv_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_decode (
        .paddr  (PADDR),
        .pwrite (PWRITE),
        .idx    (idx),
        .sel    (sel),
        .err    (addr_err)
    );

    // state_q remembers the previous bus phase; the current phase is derived from it
    // and the bus inputs so a new setup phase is accepted straight after a completion.
    always_comb begin
        phase     = IDLE;
        violation = 1'b0;
        if (PSEL) begin
            if (!PENABLE) begin
                phase = SETUP;
            end else if (state_q == IDLE) begin
                violation = 1'b1;
            end else begin
                phase = ACCESS;
            end
        end
    end

`ifdef APB3_SLV_WAIT_EN
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (phase == SETUP) begin
            cnt_d = 4'(WAIT_CYCLES);
        end else if (phase == ACCESS) begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end
        end else begin
            cnt_d = 4'd0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wait_done = (cnt_q == 4'd0);
`else
    assign wait_done = 1'b1;
`endif

    assign ready = (phase == ACCESS) && wait_done;
    assign wr_en = ready && PWRITE && !addr_err;

    always_comb begin
        state_d = IDLE;
        case (phase)
            SETUP:   state_d = SETUP;
            ACCESS:  state_d = ready ? IDLE : ACCESS;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && sel[i]) begin
                regs_d[i*DATA_WIDTH +: DATA_WIDTH] = PWDATA;
            end
        end
        if (wr_en) begin
            wr_pulse_d = sel;
        end
    end

    always_comb begin
        rd_data = (idx == IDX_W'(NUM_REGS)) ? status_in : '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel[i]) begin
                rd_data = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            regs_q     <= '0;
            wr_pulse_q <= '0;
        end else begin
            state_q    <= state_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign PREADY   = !PRESET && (ready || violation);
    assign PSLVERR  = !PRESET && (violation || (ready && addr_err));
    assign PRDATA   = (!PRESET && ready && !PWRITE && !addr_err) ? rd_data : '0;
    assign reg_out  = regs_q;
    assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_apb3_reg_slave.sv
// tb/tb_apb3_reg_slave.sv - directed self-checking bench for apb3_reg_slave
module tb_apb3_reg_slave;

`ifdef APB3_SLV_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    logic         clk;
    logic         preset;
    logic         psel;
    logic         penable;
    logic [31:0]  paddr;
    logic         pwrite;
    logic [31:0]  pwdata;
    logic [31:0]  prdata;
    logic         pready;
    logic         pslverr;
    logic [255:0] reg_out;
    logic [7:0]   wr_pulse;
    logic [31:0]  status_in;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    apb3_reg_slave #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .NUM_REGS    (8),
        .WAIT_CYCLES (2)
    ) dut (
        .PCLK      (clk),
        .PRESET    (preset),
        .PSEL      (psel),
        .PENABLE   (penable),
        .PADDR     (paddr),
        .PWRITE    (pwrite),
        .PWDATA    (pwdata),
        .PRDATA    (prdata),
        .PREADY    (pready),
        .PSLVERR   (pslverr),
        .reg_out   (reg_out),
        .wr_pulse  (wr_pulse),
        .status_in (status_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1; leaves the bus idle so a following call is back-to-back
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int acc);
        logic done;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        acc = 0; rd = '0; err = 1'b0; done = 1'b0;
        while (!done && acc < 40) begin
            @(negedge clk);
            acc++;
            if (pready) begin
                rd = prdata; err = pslverr; done = 1'b1;
            end
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    logic [31:0]  rd;
    logic         err;
    int           acc;
    int           t0;
    logic [255:0] exp_regs;

    initial begin
        preset = 1'b1; psel = 1'b1; penable = 1'b1; paddr = 32'h4; pwrite = 1'b0;
        pwdata = '0; status_in = '0; exp_regs = '0;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        chk("rst_pready", 256'(pready), 256'(0));
        chk("rst_pslverr", 256'(pslverr), 256'(0));
        chk("rst_prdata", 256'(prdata), 256'(0));
        chk("rst_reg_out", reg_out, 256'(0));
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        preset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            xfer(1'b0, 32'(i * 4), '0, rd, err, acc);
            chk($sformatf("rst_read_%0d", i), 256'(rd), 256'(0));
            chk($sformatf("rst_err_%0d", i), 256'(err), 256'(0));
        end

        xfer(1'b1, 32'h0C, 32'hDEADBEEF, rd, err, acc);
        exp_regs[3*32 +: 32] = 32'hDEADBEEF;
        chk("w0c_access_cycles", 256'(acc), 256'(W + 1));
        chk("w0c_err", 256'(err), 256'(0));
        chk("w0c_pulse", 256'(wr_pulse), 256'(8'b0000_1000));
        chk("w0c_reg_out", reg_out, exp_regs);
        @(posedge clk); #1;
        chk("w0c_pulse_clear", 256'(wr_pulse), 256'(0));
        xfer(1'b0, 32'h0C, '0, rd, err, acc);
        chk("r0c_access_cycles", 256'(acc), 256'(W + 1));
        chk("r0c_data", 256'(rd), 256'(32'hDEADBEEF));

        status_in = 32'h1234;
        xfer(1'b0, 32'h20, '0, rd, err, acc);
        chk("r20_data", 256'(rd), 256'(32'h1234));
        chk("r20_err", 256'(err), 256'(0));
        xfer(1'b1, 32'h20, 32'hFFFF_FFFF, rd, err, acc);
        chk("w20_err", 256'(err), 256'(1));
        chk("w20_pulse", 256'(wr_pulse), 256'(0));
        chk("w20_reg_out", reg_out, exp_regs);

        xfer(1'b0, 32'h24, '0, rd, err, acc);
        chk("r24_err", 256'(err), 256'(1));
        chk("r24_data", 256'(rd), 256'(0));
        xfer(1'b1, 32'h24, 32'h1111_1111, rd, err, acc);
        chk("w24_err", 256'(err), 256'(1));
        chk("w24_pulse", 256'(wr_pulse), 256'(0));
        xfer(1'b0, 32'h05, '0, rd, err, acc);
        chk("r05_err", 256'(err), 256'(1));
        chk("r05_data", 256'(rd), 256'(0));
        xfer(1'b1, 32'h05, 32'h2222_2222, rd, err, acc);
        chk("w05_err", 256'(err), 256'(1));
        chk("w05_pulse", 256'(wr_pulse), 256'(0));
        chk("bad_addr_reg_out", reg_out, exp_regs);

        t0 = cyc;
        xfer(1'b1, 32'h00, 32'hA5, rd, err, acc);
        exp_regs[0 +: 32] = 32'hA5;
        chk("b2b_w_access_cycles", 256'(acc), 256'(W + 1));
        chk("b2b_w_pulse", 256'(wr_pulse), 256'(8'b0000_0001));
        xfer(1'b0, 32'h00, '0, rd, err, acc);
        chk("b2b_r_access_cycles", 256'(acc), 256'(W + 1));
        chk("b2b_r_data", 256'(rd), 256'(32'hA5));
        chk("b2b_total_cycles", 256'(cyc - t0), 256'(2 * (W + 2)));

        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h77;
        @(negedge clk);
        chk("viol_pready", 256'(pready), 256'(1));
        chk("viol_pslverr", 256'(pslverr), 256'(1));
        chk("viol_prdata", 256'(prdata), 256'(0));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        chk("viol_pulse", 256'(wr_pulse), 256'(0));
        chk("viol_reg_out", reg_out, exp_regs);

        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h55;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        preset = 1'b1;
        #1;
        chk("rstmid_pready", 256'(pready), 256'(0));
        @(posedge clk); #1;
        exp_regs = '0;
        chk("rstmid_state", 256'(dut.state_q), 256'(2'b00));
        chk("rstmid_reg_out", reg_out, exp_regs);
        chk("rstmid_pulse", 256'(wr_pulse), 256'(0));
        preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_after_reg_out", reg_out, exp_regs);
        chk("rstmid_after_pulse", 256'(wr_pulse), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
